// File: rtl/rr_mux_arbiter.sv
// N-channel round-robin arbiter feeding a one-entry registered N:1 mux; optional packet lock via ARB_PKT_LOCK_EN.
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle sustained with out_ready high.
// Backpressure: in_ready is combinational from out_ready; a stalled full output register blocks every input.
module rr_mux_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    input  logic                 out_ready
);

    logic               out_vld_q, out_vld_d;
    logic [WIDTH-1:0]   out_dat_q, out_dat_d;
    logic [SEL_W-1:0]   out_sel_q, out_sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               load_en;
    logic               grant_vld;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W:0]     cand;
    logic               xfer;
    logic [WIDTH-1:0]   grant_dat;
    logic [SEL_W-1:0]   ptr_next;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_t;
    lock_state_t        state_q, state_d;
    logic [SEL_W-1:0]   lock_ch_q, lock_ch_d;
`else
    logic               unused_last;
    assign unused_last = ^in_last;
`endif

    assign load_en = !out_vld_q || out_ready;

    // Rotating search from ptr; cand carries one spare bit so the wrap test works for any N.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(N))
                cand = cand - (SEL_W+1)'(N);
            if (!grant_vld && in_valid[cand[SEL_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[SEL_W-1:0];
            end
        end
`ifdef ARB_PKT_LOCK_EN
        // A locked packet owns the mux even while its producer idles.
        if (state_q == LOCKED) begin
            grant_vld = in_valid[lock_ch_q];
            grant_idx = lock_ch_q;
        end
`endif
    end

    assign xfer = load_en && grant_vld;

    always_comb begin
        in_ready  = '0;
        grant_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = rst_n && xfer;
                grant_dat   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_sel_d = out_sel_q;
        ptr_d     = ptr_q;
`ifdef ARB_PKT_LOCK_EN
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
`endif
        if (load_en)
            out_vld_d = grant_vld;
        if (xfer) begin
            out_dat_d = grant_dat;
            out_sel_d = grant_idx;
`ifdef ARB_PKT_LOCK_EN
            if (in_last[grant_idx]) begin
                ptr_d   = ptr_next;
                state_d = IDLE;
            end else begin
                state_d   = LOCKED;
                lock_ch_d = grant_idx;
            end
`else
            ptr_d = ptr_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_sel_q <= '0;
            ptr_q     <= '0;
`ifdef ARB_PKT_LOCK_EN
            state_q   <= IDLE;
            lock_ch_q <= '0;
`endif
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_sel_q <= out_sel_d;
            ptr_q     <= ptr_d;
`ifdef ARB_PKT_LOCK_EN
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_rr_mux_arbiter;
    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;
`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_last;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_sel;
    logic                 out_ready;

    int checks = 0;
    int errors = 0;

    rr_mux_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference model: output slot, rotating priority pointer and packet owner.
    bit               m_vld;
    logic [SEL_W-1:0] m_sel;
    logic [WIDTH-1:0] m_dat;
    int               m_ptr;
    bit               m_lock;
    int               m_lock_ch;
    int               e_grant;
    bit               e_xfer;
    logic [N-1:0]     e_ready;

    function automatic void model_reset();
        m_vld = 0; m_sel = '0; m_dat = '0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    endfunction

    function automatic void model_eval();
        bit load_en;
        load_en = !m_vld || out_ready;
        e_grant = -1;
        e_ready = '0;
        e_xfer  = 0;
        if (m_lock) begin
            if (in_valid[m_lock_ch]) e_grant = m_lock_ch;
        end else begin
            for (int k = 0; k < N; k++)
                if (e_grant < 0 && in_valid[(m_ptr + k) % N]) e_grant = (m_ptr + k) % N;
        end
        if (load_en && e_grant >= 0) begin
            e_ready[e_grant] = 1'b1;
            e_xfer = 1;
        end
    endfunction

    function automatic void model_advance();
        if (e_xfer) begin
            m_vld = 1;
            m_sel = e_grant[SEL_W-1:0];
            m_dat = in_data[e_grant*WIDTH +: WIDTH];
            if (!LOCK || in_last[e_grant]) begin
                m_ptr  = (e_grant + 1) % N;
                m_lock = 0;
            end else begin
                m_lock    = 1;
                m_lock_ch = e_grant;
            end
        end else if (!m_vld || out_ready) begin
            m_vld = 0;
        end
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = '1; in_last = '1; in_data = 32'h88442211; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", out_sel); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", in_ready); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant got %b want 0001", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'h11)
            begin errors++; $display("FAIL reset_first_beat got v=%b sel=%0d dat=%h want v=1 sel=0 dat=11", out_valid, out_sel, out_data); end
    endtask

    task automatic test_rotation();
        int rot[6] = '{0, 1, 2, 3, 0, 1};
        logic [WIDTH-1:0] dat[4] = '{8'h11, 8'h22, 8'h44, 8'h88};
        do_reset();
        in_valid = '1; in_last = '1; in_data = 32'h88442211; out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rot_empty got %b want 0", out_valid); end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || out_sel !== rot[i-1][SEL_W-1:0] || out_data !== dat[rot[i-1]])
                    begin errors++; $display("FAIL rot_beat%0d got v=%b sel=%0d dat=%h want v=1 sel=%0d dat=%h", i, out_valid, out_sel, out_data, rot[i-1], dat[rot[i-1]]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int beats = 0;
        do_reset();
        in_valid = 4'b0100; in_last = '1; in_data = 32'h00440000; out_ready = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", in_ready); end
        @(posedge clk); #1;
        in_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h44 || out_sel !== 2'd2 || in_ready !== 4'b0000)
                begin errors++; $display("FAIL bp_stall%0d got v=%b dat=%h sel=%0d rdy=%b want v=1 dat=44 sel=2 rdy=0000", i, out_valid, out_data, out_sel, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) beats++;
            @(posedge clk); #1;
        end
        checks++; if (beats != 1) begin errors++; $display("FAIL bp_release_beats got %0d want 1", beats); end
    endtask

    task automatic test_wrap();
        do_reset();
        in_valid = 4'b1000; in_last = '1; in_data = 32'h88442211; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ch3 got %b want 1000", in_ready); end
        @(posedge clk); #1;
        in_valid = 4'b1010;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ch1 got %b want 0010", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b1000 || out_sel !== 2'd1) begin errors++; $display("FAIL wrap_then_ch3 got rdy=%b sel=%0d want rdy=1000 sel=1", in_ready, out_sel); end
        @(posedge clk); #1;
        in_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 4'b1000 || out_sel !== 2'd3) begin errors++; $display("FAIL wrap_only_ch3_%0d got rdy=%b sel=%0d want rdy=1000 sel=3", i, in_ready, out_sel); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_valid = '1; in_last = '1; in_data = 32'h88442211; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3; rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_sel !== 2'd0) begin errors++; $display("FAIL midrst_async got v=%b sel=%0d want v=0 sel=0", out_valid, out_sel); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant got %b want 0001", in_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0) begin errors++; $display("FAIL midrst_beat got v=%b sel=%0d want v=1 sel=0", out_valid, out_sel); end
    endtask

`ifdef ARB_PKT_LOCK_EN
    task automatic test_pkt_lock();
        logic [N-1:0] exp_a[4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [N-1:0] exp_b[5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0010};
        do_reset();
        in_valid = 4'b0011; in_last = 4'b0010; in_data = 32'h0000B0A0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== exp_a[i]) begin errors++; $display("FAIL lock_pkt%0d got %b want %b", i, in_ready, exp_a[i]); end
            if (i > 0) begin
                checks++; if (out_sel !== 2'd0) begin errors++; $display("FAIL lock_sel%0d got %0d want 0", i, out_sel); end
            end
            @(posedge clk); #1;
            in_data[7:0] = 8'hA1 + 8'(i);
            if (i == 1) in_last[0] = 1'b1;
            if (i == 2) in_valid[0] = 1'b0;
        end
        @(negedge clk);
        checks++; if (out_sel !== 2'd1) begin errors++; $display("FAIL lock_after_sel got %0d want 1", out_sel); end
        do_reset();
        in_valid = 4'b0011; in_last = 4'b0010; in_data = 32'h0000B0A0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== exp_b[i]) begin errors++; $display("FAIL lock_stall%0d got %b want %b", i, in_ready, exp_b[i]); end
            @(posedge clk); #1;
            if (i == 0) in_valid[0] = 1'b0;
            if (i == 2) begin in_valid[0] = 1'b1; in_last[0] = 1'b1; end
            if (i == 3) in_valid[0] = 1'b0;
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] done;
        do_reset();
        done = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!in_valid[c] || done[c]) begin
                    in_valid[c] = ($urandom_range(0, 2) != 0);
                    in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
                    in_last[c] = ($urandom_range(0, 2) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_eval();
            checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", cyc, in_ready, e_ready); end
            checks++; if (out_valid !== m_vld) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", cyc, out_valid, m_vld); end
            if (m_vld) begin
                checks++; if (out_sel !== m_sel || out_data !== m_dat)
                    begin errors++; $display("FAIL rand_beat cyc %0d got sel=%0d dat=%h want sel=%0d dat=%h", cyc, out_sel, out_data, m_sel, m_dat); end
            end
            done = e_ready;
            model_advance();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef ARB_PKT_LOCK_EN
        test_pkt_lock();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
